// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encoding, default widths and zero-count helper for the accumulation array
package cmp_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;
  localparam int DEF_DATA_WID = 16;
  localparam int DEF_ACC_WID  = 48;
  localparam int MAX_LANES    = 64;
  function automatic logic [6:0] zero_count(input logic [MAX_LANES-1:0] z);
    zero_count = '0;
    for (int i = 0; i < MAX_LANES; i++) zero_count = zero_count + 7'(z[i]);
  endfunction
endpackage

// File: rtl/cmp_pe.sv
// cmp_pe: signed multiply-accumulate cell that holds its sum when either operand is zero
module cmp_pe
  import cmp_pkg::*;
#(
  parameter int DATA_WID = DEF_DATA_WID,
  parameter int ACC_WID  = DEF_ACC_WID
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [DATA_WID-1:0] pixel,
  input  logic [DATA_WID-1:0] weight,
  output logic [ACC_WID-1:0]  acc
);
  logic signed [2*DATA_WID-1:0] prod;
  logic [ACC_WID-1:0] acc_q, acc_d;
  logic skip;
  assign prod  = $signed(pixel) * $signed(weight);
  assign skip  = (pixel == '0) || (weight == '0);
  assign acc_d = clr ? '0 : (en && !skip) ? acc_q + ACC_WID'(prod) : acc_q;
  assign acc   = acc_q;
  always_ff @(posedge clock or posedge rst)
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
endmodule

// File: rtl/cmp_array_acc.sv
// cmp_array_acc: ROWS x COLS outer-product accumulator with job FSM, row-serial drain and skip statistics
module cmp_array_acc
  import cmp_pkg::*;
#(
  parameter int DATA_WID = DEF_DATA_WID,
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int ACC_WID  = DEF_ACC_WID,
  parameter int K_WID    = 16,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic                            start,
  input  logic [K_WID-1:0]                cfg_k,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [COLS-1:0][DATA_WID-1:0]   weights,
  input  logic [ROWS-1:0][DATA_WID-1:0]   pixels,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [RW-1:0]                   out_row_idx,
  output logic [COLS-1:0][ACC_WID-1:0]    out_psums,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     skip_cnt
);
  if (ACC_WID < 2*DATA_WID) begin : g_bad_acc
    $error("ACC_WID must be at least 2*DATA_WID");
  end
  if (ROWS > MAX_LANES || COLS > MAX_LANES) begin : g_bad_lanes
    $error("ROWS and COLS must not exceed MAX_LANES");
  end
  state_e state_q, state_d;
  logic [K_WID-1:0] k_q, k_d, beat_q, beat_d;
  logic [RW-1:0] row_q, row_d;
  logic [31:0] skip_q, skip_d, zp, zw, inc;
  logic [32:0] skip_sum;
  logic done_q;
  logic [MAX_LANES-1:0] zpix, zwgt;
  logic [ROWS-1:0][COLS-1:0][ACC_WID-1:0] acc;
  logic start_ok, beat_acc, last_beat, out_hs, last_row;
  assign start_ok  = (state_q == IDLE) && start && (cfg_k != '0);
  assign beat_acc  = (state_q == ACCUM) && in_valid;
  assign last_beat = beat_acc && (beat_q == k_q - K_WID'(1));
  assign out_hs    = (state_q == DRAIN) && out_ready;
  assign last_row  = out_hs && (row_q == RW'(ROWS-1));
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_ok  ? ACCUM : IDLE;
      ACCUM:   state_d = last_beat ? DRAIN : ACCUM;
      DRAIN:   state_d = last_row  ? IDLE  : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  assign k_d    = start_ok ? cfg_k : k_q;
  assign beat_d = start_ok ? '0 : beat_acc ? beat_q + K_WID'(1) : beat_q;
  assign row_d  = last_row ? '0 : out_hs ? row_q + RW'(1) : row_q;
  always_comb begin
    zpix = '0;
    zwgt = '0;
    for (int i = 0; i < ROWS; i++) zpix[i] = (pixels[i] == '0);
    for (int i = 0; i < COLS; i++) zwgt[i] = (weights[i] == '0);
  end
  // pixel-zero rows and weight-zero columns overlap at zp*zw PEs
  assign zp       = 32'(zero_count(zpix));
  assign zw       = 32'(zero_count(zwgt));
  assign inc      = zp * COLS + zw * ROWS - zp * zw;
  assign skip_sum = {1'b0, skip_q} + {1'b0, inc};
  assign skip_d   = start_ok ? '0 : beat_acc ? (skip_sum[32] ? '1 : skip_sum[31:0]) : skip_q;
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      row_q   <= '0;
      skip_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      skip_q  <= skip_d;
      done_q  <= last_row;
    end
  for (genvar m = 0; m < ROWS; m++) begin : g_row
    for (genvar n = 0; n < COLS; n++) begin : g_col
      cmp_pe #(.DATA_WID(DATA_WID), .ACC_WID(ACC_WID)) u_pe (
        .clock  (clock),
        .rst    (rst),
        .clr    (start_ok),
        .en     (beat_acc),
        .pixel  (pixels[m]),
        .weight (weights[n]),
        .acc    (acc[m][n])
      );
    end
  end
  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == DRAIN);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign out_row_idx = row_q;
  assign out_psums   = acc[row_q];
  assign skip_cnt    = skip_q;
endmodule

// File: tb/tb_cmp_array_acc.sv
// tb_cmp_array_acc: directed self-checking bench for the outer-product accumulation array
module tb_cmp_array_acc;
  localparam int DW = 16, R = 8, C = 8, AW = 48, KW = 16, RW = 3;
  logic clock = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [KW-1:0] cfg_k = '0;
  logic [C-1:0][DW-1:0] weights = '0;
  logic [R-1:0][DW-1:0] pixels = '0;
  logic in_ready, out_valid, busy, done;
  logic [RW-1:0] out_row_idx;
  logic [C-1:0][AW-1:0] out_psums;
  logic [31:0] skip_cnt;
  logic [AW-1:0] e [R][C];
  int n_cmp = 0, n_bad = 0;

  cmp_array_acc #(.DATA_WID(DW), .ROWS(R), .COLS(C), .ACC_WID(AW), .K_WID(KW)) dut (
    .clock(clock), .rst(rst), .start(start), .cfg_k(cfg_k), .in_valid(in_valid),
    .in_ready(in_ready), .weights(weights), .pixels(pixels), .out_valid(out_valid),
    .out_ready(out_ready), .out_row_idx(out_row_idx), .out_psums(out_psums),
    .busy(busy), .done(done), .skip_cnt(skip_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input logic [DW-1:0] pv, input logic [DW-1:0] wv);
    for (int i = 0; i < R; i++) pixels[i] = pv;
    for (int i = 0; i < C; i++) weights[i] = wv;
  endtask

  task automatic set_exp(input logic [AW-1:0] v);
    for (int m = 0; m < R; m++)
      for (int n = 0; n < C; n++) e[m][n] = v;
  endtask

  task automatic start_job(input int k);
    start = 1'b1;
    cfg_k = KW'(k);
    tick;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("in_ready_accum", 64'(in_ready), 64'd1);
  endtask

  task automatic beat;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int stall_row);
    out_ready = 1'b1;
    for (int r = 0; r < R; r++) begin
      if (r == stall_row) begin
        out_ready = 1'b0;
        repeat (5) begin
          tick;
          chk({tag, " stall_valid"}, 64'(out_valid), 64'd1);
          chk({tag, " stall_idx"}, 64'(out_row_idx), 64'(r));
          chk({tag, " stall_p0"}, 64'(out_psums[0]), 64'(e[r][0]));
          chk({tag, " stall_p7"}, 64'(out_psums[C-1]), 64'(e[r][C-1]));
        end
        out_ready = 1'b1;
      end
      chk($sformatf("%s valid r%0d", tag, r), 64'(out_valid), 64'd1);
      chk($sformatf("%s idx r%0d", tag, r), 64'(out_row_idx), 64'(r));
      for (int n = 0; n < C; n++)
        chk($sformatf("%s psum r%0d c%0d", tag, r, n), 64'(out_psums[n]), 64'(e[r][n]));
      tick;
    end
    out_ready = 1'b0;
    chk({tag, " done_pulse"}, 64'(done), 64'd1);
    chk({tag, " busy_end"}, 64'(busy), 64'd0);
    chk({tag, " valid_end"}, 64'(out_valid), 64'd0);
    tick;
    chk({tag, " done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_idx", 64'(out_row_idx), 64'd0);
    chk("rst_skip", 64'(skip_cnt), 64'd0);
    chk("rst_psum0", 64'(out_psums[0]), 64'd0);
    tick;
    rst = 1'b0;
    tick;

    // start with cfg_k==0 is ignored
    start = 1'b1;
    cfg_k = '0;
    tick;
    start = 1'b0;
    chk("k0_busy", 64'(busy), 64'd0);
    chk("k0_in_ready", 64'(in_ready), 64'd0);

    // single beat, all lanes 1*2
    start_job(1);
    set_ops(16'd1, 16'd2);
    beat;
    chk("t1_latency", 64'(out_valid), 64'd1);
    set_exp(48'd2);
    drain("t1", -1);
    chk("t1_skip", 64'(skip_cnt), 64'd0);

    // signed operands
    start_job(1);
    set_ops(16'd1, 16'd1);
    pixels[0] = 16'hFFFD;
    weights[0] = 16'd5;
    beat;
    set_exp(48'd1);
    for (int n = 1; n < C; n++) e[0][n] = 48'hFFFF_FFFF_FFFD;
    for (int m = 1; m < R; m++) e[m][0] = 48'd5;
    e[0][0] = 48'hFFFF_FFFF_FFF1;
    drain("t2", -1);

    // three beats with gaps; a start during ACCUM must be ignored
    start_job(3);
    set_ops(16'd1000, 16'd1000);
    beat;
    start = 1'b1;
    cfg_k = 16'd7;
    tick;
    start = 1'b0;
    chk("t3_gap_busy", 64'(busy), 64'd1);
    chk("t3_gap_valid", 64'(out_valid), 64'd0);
    beat;
    chk("t3_beat2_valid", 64'(out_valid), 64'd0);
    tick;
    beat;
    chk("t3_latency", 64'(out_valid), 64'd1);
    set_exp(48'd3000000);
    drain("t3", -1);

    // zero skipping
    start_job(1);
    set_ops(16'd1, 16'd1);
    pixels[0] = 16'd0;
    weights[0] = 16'd0;
    beat;
    set_exp(48'd1);
    for (int n = 0; n < C; n++) e[0][n] = 48'd0;
    for (int m = 0; m < R; m++) e[m][0] = 48'd0;
    drain("t4", -1);
    chk("t4_skip_hold", 64'(skip_cnt), 64'd15);

    // backpressure at row 3, distinct row/column values
    start_job(1);
    for (int i = 0; i < R; i++) pixels[i] = DW'(i + 1);
    for (int i = 0; i < C; i++) weights[i] = DW'(i + 1);
    beat;
    for (int m = 0; m < R; m++)
      for (int n = 0; n < C; n++) e[m][n] = AW'((m + 1) * (n + 1));
    drain("t5", 3);

    // asynchronous abort mid-job
    start_job(4);
    set_ops(16'd1, 16'd1);
    pixels[0] = 16'd0;
    beat;
    beat;
    chk("t6_skip_pre", 64'(skip_cnt), 64'd16);
    chk("t6_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_skip", 64'(skip_cnt), 64'd0);
    chk("t6_psum", 64'(out_psums[1]), 64'd0);
    tick;
    rst = 1'b0;
    tick;
    chk("t6_no_done", 64'(done), 64'd0);
    start_job(1);
    set_ops(16'd1, 16'd3);
    beat;
    set_exp(48'd3);
    drain("t6", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cmp_array_acc.md
Name: cmp_array_acc

Overview:
Parametrised ROWS x COLS outer-product accumulation array with zero-operand skipping.
- Each input beat carries COLS weights and ROWS pixels; PE[m][n] accumulates pixel[m]*weight[n] over a programmable number of beats (cfg_k).
- After the last beat, results drain row-serially over a valid/ready stream.
- Successor of the fixed SIZE x SIZE compute layer; adds a job FSM, handshakes, backpressure and skip statistics.

Parameters:
DATA_WID, 16, operand width (signed two's complement)
ROWS, 8, pixel lanes (array rows)
COLS, 8, weight lanes (array columns)
ACC_WID, 48, accumulator width; must be >= 2*DATA_WID (elaboration-time assertion)
K_WID, 16, width of the beat-count config

Ports:
clock  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  job start request, honoured only in IDLE
cfg_k  in  K_WID  beats per job, sampled on accepted start
in_valid  in  1  input beat valid
in_ready  out  1  array accepts beat
weights  in  [COLS][DATA_WID]  weight vector
pixels  in  [ROWS][DATA_WID]  pixel vector
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts row
out_row_idx  out  $clog2(ROWS)  index of the row on out_psums
out_psums  out  [COLS][ACC_WID]  accumulators of the current row
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last row handshake
skip_cnt  out  32  skipped PE operations in the current or last job

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; all accumulators, counters and skip_cnt go to 0.
  - in_ready, out_valid, busy, done and out_row_idx are 0.
  - Reset mid-job aborts immediately: no done pulse and no partial output.
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - in_ready=0; incoming beats are not accepted.
  - start=1 with cfg_k!=0: latch cfg_k, clear all accumulators, clear skip_cnt and the beat counter, then enter ACCUM next cycle.
  - start with cfg_k==0 is ignored.
  - start in any other state is ignored.
- ACCUM:
  - in_ready=1.
  - Accepted beat (in_valid & in_ready): every PE updates at that clock edge.
  - When the accepted beat is beat number k (the counter equals k-1), the next state is DRAIN; the final sum is already registered on entry.
  - Gaps in in_valid are allowed; the PEs hold their values.
- PE arithmetic:
  - Full signed product, 2*DATA_WID bits, sign-extended to ACC_WID and added.
  - Wrap-around modulo 2^ACC_WID; no saturation.
  - If pixel[m]==0 or weight[n]==0, the PE skips: the accumulator holds (mathematically identical, saves power).
- skip_cnt:
  - Per accepted beat, add zp*COLS + zw*ROWS - zp*zw, where zp is the number of zero pixels and zw is the number of zero weights.
  - Saturates at 2^32-1.
  - Holds its value after the job until the next start.
- DRAIN:
  - out_valid=1, out_row_idx=r, out_psums=acc[r][0..COLS-1]; r starts at 0.
  - On out_valid & out_ready: r increments.
  - On handshake at r=ROWS-1: done=1 for one cycle, state goes to IDLE, out_valid goes to 0.
  - While out_ready=0: out_row_idx and out_psums stay stable.
- Accumulators retain their results in IDLE until the next accepted start.
- Latency: first out_valid occurs 1 cycle after the k-th accepted beat. Minimum job length is 1 + k + ROWS cycles with no stalls.

Decomposition:
- Package cmp_pkg holds:
  - the state enum typedef (IDLE/ACCUM/DRAIN);
  - default width constants (DATA_WID, ACC_WID);
  - a popcount-of-zeros function used for skip_cnt.
- Sub-module cmp_pe: one MAC cell with ports clock, rst, clr, en, pixel, weight, acc.
  - It performs the zero-skip test internally.
  - It is instantiated ROWS x COLS in a generate loop.
- The top level contains the FSM, counters, skip_cnt logic and the drain mux.

Test Plan:
- Single-beat job (defaults): start, cfg_k=1; pixels all 1, weights all 2. Expect 8 rows, out_row_idx 0..7, each out_psums lane=2; done pulses once after row 7; busy=0 afterwards; skip_cnt=0.
- Signed operands: k=1, pixel[0]=16'hFFFD (-3), weight[0]=5, others 1.
  - acc[0][0]=48'hFFFF_FFFF_FFF1 (-15).
  - acc[0][n>0]=-3, acc[m>0][0]=5, others 1.
- Accumulation with gaps: k=3, all pixels and weights=1000, in_valid toggling every other cycle. Every lane=3,000,000; DRAIN entered exactly 1 cycle after the 3rd accepted beat.
- Zero-skip: k=1, pixel[0]=0, weight[0]=0, others 1.
  - Row 0 and column 0 are all 0; others are 1.
  - skip_cnt=15.
- Backpressure: hold out_ready=0 for 5 cycles while out_row_idx=3. out_valid stays 1, row index and data stay stable, and nothing is skipped or duplicated.
- Abort and illegal controls:
  - Assert rst after 2 of 4 beats: busy=0 asynchronously, no done, all outputs 0; a new job then completes correctly.
  - start during ACCUM is ignored.
  - start with cfg_k=0 leaves the FSM in IDLE.
